// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions for the register responder.
// Contents: bus width constants, channel A/D opcode enums, the packed
// host-to-device and device-to-host channel structs, the response-buffer
// entry type and the request decode-error helper.
package tlul_pkg;

   localparam int unsigned TL_AW  = 8;
   localparam int unsigned TL_DW  = 32;
   localparam int unsigned TL_SW  = 4;
   localparam int unsigned TL_DBW = 4;

   typedef enum logic [2:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      Get            = 3'h4
   } tl_a_op_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'h0,
      AccessAckData = 3'h1
   } tl_d_op_e;

   typedef struct packed {
      logic              a_valid;
      logic [2:0]        a_opcode;
      logic [TL_AW-1:0]  a_address;
      logic [TL_DW-1:0]  a_data;
      logic [TL_DBW-1:0] a_mask;
      logic [TL_SW-1:0]  a_source;
      logic              d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic             d_valid;
      logic [2:0]       d_opcode;
      logic [TL_DW-1:0] d_data;
      logic [TL_SW-1:0] d_source;
      logic             d_error;
      logic             a_ready;
   } tl_d2h_t;

   // One buffered response.
   typedef struct packed {
      logic [2:0]       d_opcode;
      logic [TL_DW-1:0] d_data;
      logic [TL_SW-1:0] d_source;
      logic             d_error;
   } tl_rsp_t;

   // Request is erroneous if it targets a missing register, is not word
   // aligned, uses an unsupported opcode, or is a full put without all lanes.
   function automatic logic req_err(input logic [2:0]        op,
                                    input logic [TL_AW-1:0]  addr,
                                    input logic [TL_DBW-1:0] mask,
                                    input int unsigned       nregs);
      logic bad_idx;
      logic bad_align;
      logic bad_op;
      logic bad_mask;
      bad_idx   = ({26'd0, addr[7:2]} >= nregs);
      bad_align = (addr[1:0] != 2'b00);
      bad_op    = !((op == PutFullData) || (op == PutPartialData) || (op == Get));
      bad_mask  = (op == PutFullData) && (mask != 4'hF);
      return bad_idx || bad_align || bad_op || bad_mask;
   endfunction

endpackage

// File: rtl/tlul_reg_responder_if.sv
// TL-UL bus bundle between a host and the register responder.
//   h2d : channel A request plus d_ready (driven by the host)
//   d2h : channel D response plus a_ready (driven by the device)
// Modports: master (host side), slave (device side).
interface tlul_reg_responder_if;
   import tlul_pkg::*;

   tl_h2d_t h2d;
   tl_d2h_t d2h;

   modport master (output h2d, input d2h);
   modport slave  (input h2d, output d2h);

endinterface

// File: rtl/tlul_rsp_fifo.sv
// Response buffer for the register responder: an in-order FIFO of tl_rsp_t.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset (empties the buffer)
//   push, wdata   : enqueue request and entry
//   pop           : dequeue request (head is consumed)
//   rdata         : head entry, meaningful while !empty
//   full, empty   : occupancy flags
module tlul_rsp_fifo
   import tlul_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic    clk_i,
   input  logic    rst_ni,
   input  logic    push,
   input  tl_rsp_t wdata,
   input  logic    pop,
   output tl_rsp_t rdata,
   output logic    full,
   output logic    empty
);

   localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CW = $clog2(Depth + 1);

   tl_rsp_t         mem [Depth];
   logic [PW-1:0]   wptr;
   logic [PW-1:0]   rptr;
   logic [CW-1:0]   cnt;
   logic            do_push;
   logic            do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full  = (cnt == CW'(Depth));
   assign empty = (cnt == '0);

   // A simultaneous pop frees the slot a push needs, so push-while-full is
   // legal when paired with a pop.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) wptr <= ptr_inc(wptr);
         if (do_pop)  rptr <= ptr_inc(rptr);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wptr] <= wdata;
   end

   assign rdata = mem[rptr];

endmodule

// File: rtl/tlul_reg_responder.sv
// TL-UL device-side CSR endpoint serving NumRegs 32-bit registers.
// Requests are decoded at acceptance; each yields one response that is
// queued in an in-order buffer so back-to-back requests can be taken while
// the host stalls channel D.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : synchronous active-low reset
//   tl     : TL-UL slave bundle (channel A in, channel D out, a_ready/d_ready)
//   regs_o : flattened register contents, reg k at [k*32 +: 32]
module tlul_reg_responder
   import tlul_pkg::*;
#(
   parameter int unsigned NumRegs     = 8,
   parameter int unsigned RspDepth    = 2,
   parameter logic [31:0] RegResetVal = 32'h0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   tlul_reg_responder_if.slave     tl,
   output logic [NumRegs*32-1:0]   regs_o
);

   logic [NumRegs-1:0][31:0] regs_q;
   logic                     rdy_q;
   logic                     full;
   logic                     empty;
   logic                     a_ready;
   logic                     accept_p0;
   logic                     err_p0;
   logic                     wr_en_p0;
   logic [5:0]               idx_p0;
   logic [31:0]              rd_data_p0;
   tl_rsp_t                  rsp_p0;
   tl_rsp_t                  rsp_p1;
   tl_d2h_t                  d2h;

   // ---- Stage p0: acceptance and decode --------------------------------
   // a_ready comes from buffer occupancy only; rdy_q keeps it low while in
   // reset and raises it on the first cycle after release.
   assign a_ready   = rdy_q && !full;
   assign accept_p0 = tl.h2d.a_valid && a_ready;
   assign idx_p0    = tl.h2d.a_address[7:2];
   assign err_p0    = req_err(tl.h2d.a_opcode, tl.h2d.a_address,
                              tl.h2d.a_mask, NumRegs);
   assign wr_en_p0  = accept_p0 && !err_p0 &&
                      ((tl.h2d.a_opcode == PutFullData) ||
                       (tl.h2d.a_opcode == PutPartialData));

   always_comb begin
      rd_data_p0 = '0;
      for (int k = 0; k < NumRegs; k++) begin
         if (idx_p0 == 6'(k)) rd_data_p0 = regs_q[k];
      end
   end

   always_comb begin
      rsp_p0          = '0;
      rsp_p0.d_source = tl.h2d.a_source;
      rsp_p0.d_error  = err_p0;
      rsp_p0.d_opcode = (tl.h2d.a_opcode == Get) ? AccessAckData : AccessAck;
      if ((tl.h2d.a_opcode == Get) && !err_p0) rsp_p0.d_data = rd_data_p0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) rdy_q <= 1'b0;
      else         rdy_q <= 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int k = 0; k < NumRegs; k++) regs_q[k] <= RegResetVal;
      end else if (wr_en_p0) begin
         for (int k = 0; k < NumRegs; k++) begin
            for (int b = 0; b < 4; b++) begin
               if ((idx_p0 == 6'(k)) && tl.h2d.a_mask[b])
                  regs_q[k][8*b +: 8] <= tl.h2d.a_data[8*b +: 8];
            end
         end
      end
   end

   assign regs_o = regs_q;

   // ---- Stage p1: response buffer and channel D ------------------------
   tlul_rsp_fifo #(.Depth(RspDepth)) u_rsp_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (accept_p0),
      .wdata  (rsp_p0),
      .pop    (tl.h2d.d_ready),
      .rdata  (rsp_p1),
      .full   (full),
      .empty  (empty)
   );

   // Channel D fields read as zero whenever nothing is pending, which also
   // covers the reset state.
   always_comb begin
      d2h         = '0;
      d2h.a_ready = a_ready;
      if (!empty) begin
         d2h.d_valid  = 1'b1;
         d2h.d_opcode = rsp_p1.d_opcode;
         d2h.d_data   = rsp_p1.d_data;
         d2h.d_source = rsp_p1.d_source;
         d2h.d_error  = rsp_p1.d_error;
      end
   end

   assign tl.d2h = d2h;

endmodule

// File: tb/tb_tlul_reg_responder.sv
// Directed testbench for tlul_reg_responder (NumRegs=8, RspDepth=2).
module tb_tlul_reg_responder;
   import tlul_pkg::*;

   logic           clk_i;
   logic           rst_ni;
   logic [255:0]   regs;
   int             n_chk;
   int             n_fail;

   tlul_reg_responder_if bus ();

   tlul_reg_responder #(
      .NumRegs     (8),
      .RspDepth    (2),
      .RegResetVal (32'h0)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .tl     (bus.slave),
      .regs_o (regs)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_a(input logic [2:0] op, input logic [7:0] addr,
                          input logic [31:0] data, input logic [3:0] mask,
                          input logic [3:0] src);
      bus.h2d.a_valid   = 1'b1;
      bus.h2d.a_opcode  = op;
      bus.h2d.a_address = addr;
      bus.h2d.a_data    = data;
      bus.h2d.a_mask    = mask;
      bus.h2d.a_source  = src;
   endtask

   // Present a request, wait (bounded) for a_ready, let it be accepted.
   task automatic send(input string tag, input logic [2:0] op,
                       input logic [7:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, input logic [3:0] src);
      drive_a(op, addr, data, mask, src);
      for (int i = 0; i < 20 && !bus.d2h.a_ready; i++) step();
      check({tag, "_ardy"}, 64'(bus.d2h.a_ready), 64'd1);
      step();
      bus.h2d.a_valid = 1'b0;
   endtask

   task automatic check_rsp(input string tag, input logic [2:0] op,
                            input logic [31:0] data, input logic [3:0] src,
                            input logic err);
      check({tag, "_vld"}, 64'(bus.d2h.d_valid),  64'd1);
      check({tag, "_op"},  64'(bus.d2h.d_opcode), 64'(op));
      check({tag, "_dat"}, 64'(bus.d2h.d_data),   64'(data));
      check({tag, "_src"}, 64'(bus.d2h.d_source), 64'(src));
      check({tag, "_err"}, 64'(bus.d2h.d_error),  64'(err));
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      bus.h2d = '0;
      bus.h2d.d_ready = 1'b1;
      rst_ni = 1'b0;

      // Reset state
      step();
      step();
      check("rst_dvld", 64'(bus.d2h.d_valid), 64'd0);
      check("rst_ardy", 64'(bus.d2h.a_ready), 64'd0);
      check("rst_dfld", 64'({bus.d2h.d_opcode, bus.d2h.d_data,
                             bus.d2h.d_source, bus.d2h.d_error}), 64'd0);
      check("rst_regs", 64'(regs == '0), 64'd1);
      rst_ni = 1'b1;
      step();
      check("rel_ardy", 64'(bus.d2h.a_ready), 64'd1);

      // Write then read
      send("put1", PutFullData, 8'h04, 32'hDEADBEEF, 4'hF, 4'd3);
      check_rsp("put1", AccessAck, 32'h0, 4'd3, 1'b0);
      check("put1_reg", 64'(regs[63:32]), 64'hDEADBEEF);
      send("get1", Get, 8'h04, 32'h0, 4'h0, 4'd4);
      check_rsp("get1", AccessAckData, 32'hDEADBEEF, 4'd4, 1'b0);

      // Partial write, lane 1 only
      send("pp", PutPartialData, 8'h04, 32'h00001200, 4'b0010, 4'd5);
      check_rsp("pp", AccessAck, 32'h0, 4'd5, 1'b0);
      check("pp_reg", 64'(regs[63:32]), 64'hDEAD12EF);

      // Read-after-write on back-to-back cycles
      drive_a(PutFullData, 8'h08, 32'h11223344, 4'hF, 4'd6);
      step();
      check_rsp("raw_put", AccessAck, 32'h0, 4'd6, 1'b0);
      drive_a(Get, 8'h08, 32'h0, 4'hF, 4'd7);
      step();
      bus.h2d.a_valid = 1'b0;
      check_rsp("raw_get", AccessAckData, 32'h11223344, 4'd7, 1'b0);
      step();
      check("raw_drain", 64'(bus.d2h.d_valid), 64'd0);

      // Error responses
      send("e_idx", Get, 8'h20, 32'h0, 4'hF, 4'd8);
      check_rsp("e_idx", AccessAckData, 32'h0, 4'd8, 1'b1);
      send("e_aln", Get, 8'h02, 32'h0, 4'hF, 4'd9);
      check_rsp("e_aln", AccessAckData, 32'h0, 4'd9, 1'b1);
      send("e_msk", PutFullData, 8'h04, 32'hFFFFFFFF, 4'h3, 4'd10);
      check_rsp("e_msk", AccessAck, 32'h0, 4'd10, 1'b1);
      send("e_op", 3'h2, 8'h04, 32'hFFFFFFFF, 4'hF, 4'd11);
      check_rsp("e_op", AccessAck, 32'h0, 4'd11, 1'b1);
      check("e_reg1", 64'(regs[63:32]), 64'hDEAD12EF);
      check("e_reg2", 64'(regs[95:64]), 64'h11223344);
      step();

      // Backpressure: two accepted, third held
      bus.h2d.d_ready = 1'b0;
      drive_a(Get, 8'h04, 32'h0, 4'hF, 4'd0);
      step();
      drive_a(Get, 8'h04, 32'h0, 4'hF, 4'd1);
      step();
      check("bp_full_ardy", 64'(bus.d2h.a_ready), 64'd0);
      check_rsp("bp_h0", AccessAckData, 32'hDEAD12EF, 4'd0, 1'b0);
      drive_a(Get, 8'h08, 32'h0, 4'hF, 4'd2);
      step();
      check("bp_held_ardy", 64'(bus.d2h.a_ready), 64'd0);
      check_rsp("bp_stable", AccessAckData, 32'hDEAD12EF, 4'd0, 1'b0);
      bus.h2d.d_ready = 1'b1;
      step();
      check("bp_pop_ardy", 64'(bus.d2h.a_ready), 64'd1);
      check_rsp("bp_h1", AccessAckData, 32'hDEAD12EF, 4'd1, 1'b0);
      step();
      bus.h2d.a_valid = 1'b0;
      check_rsp("bp_h2", AccessAckData, 32'h11223344, 4'd2, 1'b0);
      step();
      check("bp_empty", 64'(bus.d2h.d_valid), 64'd0);

      // Reset with two responses buffered
      bus.h2d.d_ready = 1'b0;
      drive_a(PutFullData, 8'h00, 32'hA5A5A5A5, 4'hF, 4'd7);
      step();
      drive_a(Get, 8'h00, 32'h0, 4'hF, 4'd8);
      step();
      bus.h2d.a_valid = 1'b0;
      check("mf_full", 64'(bus.d2h.a_ready), 64'd0);
      check("mf_reg0", 64'(regs[31:0]), 64'hA5A5A5A5);
      rst_ni = 1'b0;
      step();
      check("mf_dvld", 64'(bus.d2h.d_valid), 64'd0);
      check("mf_ardy", 64'(bus.d2h.a_ready), 64'd0);
      check("mf_regs", 64'(regs == '0), 64'd1);
      rst_ni = 1'b1;
      bus.h2d.d_ready = 1'b1;
      step();
      check("mf_rel_ardy", 64'(bus.d2h.a_ready), 64'd1);
      for (int i = 0; i < 4; i++) begin
         check("mf_no_stale", 64'(bus.d2h.d_valid), 64'd0);
         step();
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/tlul_reg_responder.md
Name: tlul_reg_responder

Overview:
- TL-UL device-side responder. Consumes host-to-device requests (tl_h2d_t) and returns device-to-host responses (tl_d2h_t).
- Serves a small bank of 32-bit registers.
- Peer of the host-side request driver: it closes the loop that tl_h2d_t opens.
- Sits behind a crossbar port as a generic CSR endpoint; buffers responses so it can accept back-to-back requests under host backpressure.

Parameters:
- NumRegs, 8, number of 32-bit registers; legal 1..64.
- RspDepth, 2, response buffer entries; legal 1..4.
- RegResetVal, 32'h0, reset value of every register.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_ni  input  1  synchronous active-low reset.
- tl_i  input  tl_h2d_t  request channel A (a_valid, a_opcode[2:0], a_address[7:0], a_data[31:0], a_mask[3:0], a_source[3:0]) plus d_ready.
- tl_o  output  tl_d2h_t  response channel D (d_valid, d_opcode[2:0], d_data[31:0], d_source[3:0], d_error) plus a_ready.
- regs_o  output  NumRegs*32  flattened register contents; reg k occupies bits [k*32 +: 32].

Behaviour:
- Reset
  - Applies when rst_ni=0 sampled at a clock edge.
  - All registers go to RegResetVal; the response buffer empties.
  - tl_o.d_valid=0, d_opcode=0, d_data=0, d_source=0, d_error=0.
  - tl_o.a_ready=0 during reset and =1 on the first cycle after release.
  - Reset mid-transaction discards all buffered responses; no response is ever emitted for them.
- Handshakes
  - a_ready = !buffer_full, combinational from buffer count only, never from a_valid.
  - A request is accepted on a cycle with a_valid && a_ready.
  - A response is consumed on a cycle with d_valid && d_ready.
- Latency
  - Buffer empty: d_valid rises the cycle after acceptance (1-cycle latency).
  - Otherwise responses leave in strict acceptance order.
- Decode, at acceptance
  - idx = a_address[7:2].
  - Error if: idx >= NumRegs, or a_address[1:0] != 0, or opcode not in {PutFullData=0, PutPartialData=1, Get=4}, or (PutFullData and a_mask != 4'hF).
- Write (Put*, no error)
  - Byte lane b of reg[idx] updates when a_mask[b]=1.
  - The write is visible on regs_o the cycle after acceptance.
  - Response: d_opcode=AccessAck(0), d_data=0.
- Read (Get, no error)
  - d_data = reg[idx] as sampled at acceptance; the mask is ignored.
  - Response: d_opcode=AccessAckData(1).
- Error response
  - No state change.
  - d_opcode = AccessAckData for Get, AccessAck otherwise (bad opcode also gets AccessAck).
  - d_data=0, d_error=1.
- d_source always echoes the accepted a_source.
- Buffer
  - Push and pop in the same cycle are legal, including when full; count is unchanged.
  - When full, a_ready=0 until a pop occurs; a request presented while a_ready=0 is not accepted and must be held by the host.
  - Pointers wrap modulo RspDepth.
  - d_* outputs are stable while d_valid && !d_ready.
- Read-after-write: a Get accepted the cycle after a Put to the same idx returns the new value.

Decomposition:
- tlul_pkg (shared) holds:
  - constants TL_AW=8, TL_DW=32, TL_SW=4, TL_DBW=4;
  - tl_a_op_e (PutFullData=0, PutPartialData=1, Get=4) and tl_d_op_e (AccessAck=0, AccessAckData=1);
  - packed structs tl_h2d_t and tl_d2h_t.
- Sub-module tlul_rsp_fifo: parameterised depth, synchronous active-low reset, entry type {d_opcode, d_data, d_source, d_error}, outputs full/empty.
- Top level holds decode, the register bank, and error logic.

Test Plan:
- Write then read: PutFullData addr 8'h04, data 32'hDEADBEEF, mask 4'hF, source 3 -> AccessAck src 3 err 0; then Get 8'h04 -> AccessAckData 32'hDEADBEEF.
- Partial write: reg1=32'hDEADBEEF, then PutPartialData 8'h04, data 32'h00001200, mask 4'b0010 -> regs_o[63:32]=32'hDEAD12EF.
- Errors, each with d_error=1, no register change, responses in order:
  - Get 8'h20 with NumRegs=8 -> AccessAckData, data 0;
  - Get 8'h02 (misaligned) -> AccessAckData, data 0;
  - PutFullData mask 4'h3 -> AccessAck, data 0;
  - opcode 3'h2 -> AccessAck, data 0.
- Backpressure with d_ready=0: 2 Gets accepted, third held (a_ready=0); d_ready=1 in one cycle -> push and pop together, d_source order 0,1,2, d_* stable while stalled.
- Reset mid-flight: 2 responses buffered, rst_ni=0 for 1 cycle -> d_valid=0, regs_o all RegResetVal, a_ready=1 on the next cycle, no stale responses emitted.
